// File: rtl/decode_pkg.sv
// Shared decode definitions: control bundle, opcode/funct constants and
// the per-class control encodings used by every decode slot.
package decode_pkg;

  typedef struct packed {
    logic       wreg;
    logic       regdst;
    logic       use_imm;
    logic       branch;
    logic       wmem;
    logic       rmem;
    logic       jump;
    logic       jal;
    logic       jr;
    logic       bal;
    logic       jalr;
    logic [4:0] alucontrol;
    logic       memen;
    logic [1:0] whilo;
    logic       wcp0;
    logic       invalid;
  } decode_bus_t;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;
  localparam logic [5:0] FN_SLLV    = 6'h04;
  localparam logic [5:0] FN_SRLV    = 6'h06;
  localparam logic [5:0] FN_SRAV    = 6'h07;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_BREAK   = 6'h0d;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_XOR     = 6'h26;
  localparam logic [5:0] FN_NOR     = 6'h27;
  localparam logic [5:0] FN_SLT     = 6'h2a;
  localparam logic [5:0] FN_SLTU    = 6'h2b;

  // REGIMM rt codes, COP0 rs codes, COP0 CO funct
  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;
  localparam logic [4:0] RS_MF      = 5'h00;
  localparam logic [4:0] RS_MT      = 5'h04;
  localparam logic [5:0] CO_ERET    = 6'h18;

  // ALU operation codes
  localparam logic [4:0] ALU_ADD    = 5'd1;
  localparam logic [4:0] ALU_ADDU   = 5'd2;
  localparam logic [4:0] ALU_SUB    = 5'd3;
  localparam logic [4:0] ALU_SUBU   = 5'd4;
  localparam logic [4:0] ALU_AND    = 5'd5;
  localparam logic [4:0] ALU_OR     = 5'd6;
  localparam logic [4:0] ALU_XOR    = 5'd7;
  localparam logic [4:0] ALU_NOR    = 5'd8;
  localparam logic [4:0] ALU_SLT    = 5'd9;
  localparam logic [4:0] ALU_SLTU   = 5'd10;
  localparam logic [4:0] ALU_SLL    = 5'd11;
  localparam logic [4:0] ALU_SRL    = 5'd12;
  localparam logic [4:0] ALU_SRA    = 5'd13;
  localparam logic [4:0] ALU_LUI    = 5'd14;
  localparam logic [4:0] ALU_MULT   = 5'd15;
  localparam logic [4:0] ALU_MULTU  = 5'd16;
  localparam logic [4:0] ALU_DIV    = 5'd17;
  localparam logic [4:0] ALU_DIVU   = 5'd18;
  localparam logic [4:0] ALU_MFHI   = 5'd19;
  localparam logic [4:0] ALU_MFLO   = 5'd20;
  localparam logic [4:0] ALU_MTHI   = 5'd21;
  localparam logic [4:0] ALU_MTLO   = 5'd22;
  localparam logic [4:0] ALU_SLLV   = 5'd23;
  localparam logic [4:0] ALU_SRLV   = 5'd24;
  localparam logic [4:0] ALU_SRAV   = 5'd25;

  // Per-class control encodings; alucontrol filled in per instruction where it varies
  localparam decode_bus_t INVALID_DECODE = '{invalid: 1'b1, default: '0};
  localparam decode_bus_t TRAP_DECODE    = '{default: '0};
  localparam decode_bus_t RTYPE_DECODE   = '{wreg: 1'b1, regdst: 1'b1, default: '0};
  localparam decode_bus_t ITYPE_DECODE   = '{wreg: 1'b1, use_imm: 1'b1, default: '0};
  localparam decode_bus_t LOAD_DECODE    = '{wreg: 1'b1, use_imm: 1'b1, rmem: 1'b1, memen: 1'b1,
                                             alucontrol: ALU_ADDU, default: '0};
  localparam decode_bus_t STORE_DECODE   = '{use_imm: 1'b1, wmem: 1'b1, memen: 1'b1,
                                             alucontrol: ALU_ADDU, default: '0};
  localparam decode_bus_t BRANCH_DECODE  = '{branch: 1'b1, default: '0};
  localparam decode_bus_t BAL_DECODE     = '{branch: 1'b1, bal: 1'b1, wreg: 1'b1, default: '0};
  localparam decode_bus_t J_DECODE       = '{jump: 1'b1, default: '0};
  localparam decode_bus_t JAL_DECODE     = '{jump: 1'b1, jal: 1'b1, wreg: 1'b1, default: '0};
  localparam decode_bus_t JR_DECODE      = '{jump: 1'b1, jr: 1'b1, default: '0};
  localparam decode_bus_t JALR_DECODE    = '{jump: 1'b1, jalr: 1'b1, wreg: 1'b1, regdst: 1'b1,
                                             default: '0};
  localparam decode_bus_t MULDIV_DECODE  = '{whilo: 2'b11, default: '0};
  localparam decode_bus_t MFHILO_DECODE  = '{wreg: 1'b1, regdst: 1'b1, default: '0};
  localparam decode_bus_t MTHI_DECODE    = '{whilo: 2'b10, alucontrol: ALU_MTHI, default: '0};
  localparam decode_bus_t MTLO_DECODE    = '{whilo: 2'b01, alucontrol: ALU_MTLO, default: '0};
  localparam decode_bus_t MFC0_DECODE    = '{wreg: 1'b1, default: '0};
  localparam decode_bus_t MTC0_DECODE    = '{wcp0: 1'b1, default: '0};
  // ERET redirects fetch without a delay slot and clears EXL
  localparam decode_bus_t ERET_DECODE    = '{jump: 1'b1, wcp0: 1'b1, default: '0};

  // Class encoding with a specific ALU operation
  function automatic decode_bus_t with_alu(input decode_bus_t base, input logic [4:0] alu);
    decode_bus_t d;
    d = base;
    d.alucontrol = alu;
    return d;
  endfunction

endpackage

// File: rtl/instr_decode_slot.sv
// Combinational single-instruction decoder producing the control bundle.
module instr_decode_slot
  import decode_pkg::*;
(
  input  logic [5:0]  i_op,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [5:0]  i_funct,
  output decode_bus_t o_dec
);

  // Opcode/funct/rt/rs lookup; anything unrecognised falls back to INVALID_DECODE
  always_comb begin
    o_dec = INVALID_DECODE;
    case (i_op)
      OP_SPECIAL: begin
        case (i_funct)
          FN_SLL:              o_dec = with_alu(RTYPE_DECODE, ALU_SLL);
          FN_SRL:              o_dec = with_alu(RTYPE_DECODE, ALU_SRL);
          FN_SRA:              o_dec = with_alu(RTYPE_DECODE, ALU_SRA);
          FN_SLLV:             o_dec = with_alu(RTYPE_DECODE, ALU_SLLV);
          FN_SRLV:             o_dec = with_alu(RTYPE_DECODE, ALU_SRLV);
          FN_SRAV:             o_dec = with_alu(RTYPE_DECODE, ALU_SRAV);
          FN_JR:               o_dec = JR_DECODE;
          FN_JALR:             o_dec = JALR_DECODE;
          FN_SYSCALL, FN_BREAK: o_dec = TRAP_DECODE;
          FN_MFHI:             o_dec = with_alu(MFHILO_DECODE, ALU_MFHI);
          FN_MFLO:             o_dec = with_alu(MFHILO_DECODE, ALU_MFLO);
          FN_MTHI:             o_dec = MTHI_DECODE;
          FN_MTLO:             o_dec = MTLO_DECODE;
          FN_MULT:             o_dec = with_alu(MULDIV_DECODE, ALU_MULT);
          FN_MULTU:            o_dec = with_alu(MULDIV_DECODE, ALU_MULTU);
          FN_DIV:              o_dec = with_alu(MULDIV_DECODE, ALU_DIV);
          FN_DIVU:             o_dec = with_alu(MULDIV_DECODE, ALU_DIVU);
          FN_ADD:              o_dec = with_alu(RTYPE_DECODE, ALU_ADD);
          FN_ADDU:             o_dec = with_alu(RTYPE_DECODE, ALU_ADDU);
          FN_SUB:              o_dec = with_alu(RTYPE_DECODE, ALU_SUB);
          FN_SUBU:             o_dec = with_alu(RTYPE_DECODE, ALU_SUBU);
          FN_AND:              o_dec = with_alu(RTYPE_DECODE, ALU_AND);
          FN_OR:               o_dec = with_alu(RTYPE_DECODE, ALU_OR);
          FN_XOR:              o_dec = with_alu(RTYPE_DECODE, ALU_XOR);
          FN_NOR:              o_dec = with_alu(RTYPE_DECODE, ALU_NOR);
          FN_SLT:              o_dec = with_alu(RTYPE_DECODE, ALU_SLT);
          FN_SLTU:             o_dec = with_alu(RTYPE_DECODE, ALU_SLTU);
          default:             o_dec = INVALID_DECODE;
        endcase
      end
      OP_REGIMM: begin
        case (i_rt)
          RT_BLTZ, RT_BGEZ:     o_dec = BRANCH_DECODE;
          RT_BLTZAL, RT_BGEZAL: o_dec = BAL_DECODE;
          default:              o_dec = INVALID_DECODE;
        endcase
      end
      OP_J:                             o_dec = J_DECODE;
      OP_JAL:                           o_dec = JAL_DECODE;
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_dec = BRANCH_DECODE;
      OP_ADDI:                          o_dec = with_alu(ITYPE_DECODE, ALU_ADD);
      OP_ADDIU:                         o_dec = with_alu(ITYPE_DECODE, ALU_ADDU);
      OP_SLTI:                          o_dec = with_alu(ITYPE_DECODE, ALU_SLT);
      OP_SLTIU:                         o_dec = with_alu(ITYPE_DECODE, ALU_SLTU);
      OP_ANDI:                          o_dec = with_alu(ITYPE_DECODE, ALU_AND);
      OP_ORI:                           o_dec = with_alu(ITYPE_DECODE, ALU_OR);
      OP_XORI:                          o_dec = with_alu(ITYPE_DECODE, ALU_XOR);
      OP_LUI:                           o_dec = with_alu(ITYPE_DECODE, ALU_LUI);
      OP_COP0: begin
        if (i_rs[4]) begin
          o_dec = (i_funct == CO_ERET) ? ERET_DECODE : INVALID_DECODE;
        end else begin
          case (i_rs)
            RS_MF:   o_dec = MFC0_DECODE;
            RS_MT:   o_dec = MTC0_DECODE;
            default: o_dec = INVALID_DECODE;
          endcase
        end
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: o_dec = LOAD_DECODE;
      OP_SB, OP_SH, OP_SW:                o_dec = STORE_DECODE;
      default:                            o_dec = INVALID_DECODE;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// Instruction queue between fetch and decode: multi-lane push at tail,
// ISSUE_W decode slots presented combinationally from head.
module decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned ISSUE_W = 2,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           flush_i,
  input  logic [FETCH_W-1:0]             push_valid_i,
  input  logic [32*FETCH_W-1:0]          push_instr_i,
  input  logic [32*FETCH_W-1:0]          push_pc_i,
  output logic                           push_ready_o,
  output logic [ISSUE_W-1:0]             slot_valid_o,
  output logic [32*ISSUE_W-1:0]          slot_pc_o,
  output logic [32*ISSUE_W-1:0]          slot_instr_o,
  output decode_bus_t [ISSUE_W-1:0]      slot_dec_o,
  input  logic [$clog2(ISSUE_W+1)-1:0]   issue_cnt_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH+1);
  localparam int unsigned ICNT_W = $clog2(ISSUE_W+1);

  logic [31:0]      r_instr [DEPTH];
  logic [31:0]      r_pc    [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic              w_push_en;
  logic [CNT_W-1:0]  w_push_n;
  logic [PTR_W-1:0]  w_wr_addr  [FETCH_W];
  logic [31:0]       w_rd_instr [ISSUE_W];
  logic [31:0]       w_rd_pc    [ISSUE_W];
  decode_bus_t       w_dec      [ISSUE_W];
  logic [ICNT_W-1:0] w_nvalid;

  // Readiness depends only on the registered count, never on same-cycle issue
  assign push_ready_o = (r_count <= CNT_W'(DEPTH - FETCH_W));
  assign w_push_en    = push_ready_o & ~flush_i;
  assign count_o      = r_count;

  // Pack valid lanes densely at the tail and count them
  always_comb begin
    w_push_n = '0;
    for (int l = 0; l < FETCH_W; l++) begin
      w_wr_addr[l] = r_tail + PTR_W'(w_push_n);
      if (w_push_en && push_valid_i[l]) w_push_n = w_push_n + CNT_W'(1);
    end
  end

  // Entry storage, no reset needed since count gates every read
  always_ff @(posedge clk) begin
    for (int l = 0; l < FETCH_W; l++) begin
      if (w_push_en && push_valid_i[l]) begin
        r_instr[w_wr_addr[l]] <= push_instr_i[32*l +: 32];
        r_pc[w_wr_addr[l]]    <= push_pc_i[32*l +: 32];
      end
    end
  end

  // Head/tail/count; flush wins over push and issue, wrap is implicit in PTR_W
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + PTR_W'(issue_cnt_i);
      r_tail  <= r_tail + PTR_W'(w_push_n);
      r_count <= r_count + w_push_n - CNT_W'(issue_cnt_i);
    end
  end

  // Raw entries at head+k feeding the decoders
  always_comb begin
    for (int k = 0; k < ISSUE_W; k++) begin
      w_rd_instr[k] = r_instr[r_head + PTR_W'(k)];
      w_rd_pc[k]    = r_pc[r_head + PTR_W'(k)];
    end
  end

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_dec
    instr_decode_slot u_dec (
      .i_op    (w_rd_instr[k][31:26]),
      .i_rs    (w_rd_instr[k][25:21]),
      .i_rt    (w_rd_instr[k][20:16]),
      .i_funct (w_rd_instr[k][5:0]),
      .o_dec   (w_dec[k])
    );
  end

  // Slot validity: occupied and not behind a control transfer; invalid slots read zero
  always_comb begin
    logic v_blocked;
    v_blocked    = 1'b0;
    w_nvalid     = '0;
    slot_valid_o = '0;
    slot_pc_o    = '0;
    slot_instr_o = '0;
    slot_dec_o   = '0;
    for (int k = 0; k < ISSUE_W; k++) begin
      if ((CNT_W'(k) < r_count) && !v_blocked) begin
        slot_valid_o[k]          = 1'b1;
        slot_pc_o[32*k +: 32]    = w_rd_pc[k];
        slot_instr_o[32*k +: 32] = w_rd_instr[k];
        slot_dec_o[k]            = w_dec[k];
        w_nvalid                 = w_nvalid + ICNT_W'(1);
      end
      v_blocked = v_blocked | w_dec[k].branch | w_dec[k].jump;
    end
  end

  // Consumer may not take more slots than are presented valid
  a_issue_legal: assert property (@(posedge clk) disable iff (!resetn)
                                  flush_i || (issue_cnt_i <= w_nvalid));

endmodule

// File: tb/tb_decode_queue.sv
// Scoreboard bench for decode_queue: stimulus queues expected entries,
// a negedge monitor compares every slot consumed by issue_cnt_i.
module tb_decode_queue;
  import decode_pkg::*;

  logic              clk;
  logic              resetn;
  logic              flush_i;
  logic [1:0]        push_valid_i;
  logic [63:0]       push_instr_i;
  logic [63:0]       push_pc_i;
  logic              push_ready_o;
  logic [1:0]        slot_valid_o;
  logic [63:0]       slot_pc_o;
  logic [63:0]       slot_instr_o;
  decode_bus_t [1:0] slot_dec_o;
  logic [1:0]        issue_cnt_i;
  logic [3:0]        count_o;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    decode_bus_t dec;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n = 0;

  localparam logic [31:0] I_ADDU  = 32'h00221821;
  localparam logic [31:0] I_ORI   = 32'h34420001;
  localparam logic [31:0] I_BEQ   = 32'h10220004;
  localparam logic [31:0] I_ADDIU = 32'h24420001;
  localparam logic [31:0] I_CO19  = 32'h42000019;
  localparam logic [31:0] I_ERET  = 32'h42000018;

  decode_queue #(.FETCH_W(2), .ISSUE_W(2), .DEPTH(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flush_i      (flush_i),
    .push_valid_i (push_valid_i),
    .push_instr_i (push_instr_i),
    .push_pc_i    (push_pc_i),
    .push_ready_o (push_ready_o),
    .slot_valid_o (slot_valid_o),
    .slot_pc_o    (slot_pc_o),
    .slot_instr_o (slot_instr_o),
    .slot_dec_o   (slot_dec_o),
    .issue_cnt_i  (issue_cnt_i),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written expected control bundles
  function automatic decode_bus_t e_addu();
    decode_bus_t d = '0;
    d.wreg = 1'b1; d.regdst = 1'b1; d.alucontrol = ALU_ADDU;
    return d;
  endfunction
  function automatic decode_bus_t e_ori();
    decode_bus_t d = '0;
    d.wreg = 1'b1; d.use_imm = 1'b1; d.alucontrol = ALU_OR;
    return d;
  endfunction
  function automatic decode_bus_t e_addiu();
    decode_bus_t d = '0;
    d.wreg = 1'b1; d.use_imm = 1'b1; d.alucontrol = ALU_ADDU;
    return d;
  endfunction
  function automatic decode_bus_t e_beq();
    decode_bus_t d = '0;
    d.branch = 1'b1;
    return d;
  endfunction
  function automatic decode_bus_t e_invalid();
    decode_bus_t d = '0;
    d.invalid = 1'b1;
    return d;
  endfunction
  function automatic decode_bus_t e_eret();
    decode_bus_t d = '0;
    d.jump = 1'b1; d.wcp0 = 1'b1;
    return d;
  endfunction

  function automatic logic [31:0] ori_n(input int k);
    return 32'h34420000 | 32'(k);
  endfunction
  function automatic logic [31:0] pc_n(input int k);
    return 32'h00001000 + 32'(4 * k);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs; accepted pushes enter the scoreboard in lane order
  task automatic drive(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                       input decode_bus_t d0, input logic [31:0] i1, input logic [31:0] p1,
                       input decode_bus_t d1, input logic [1:0] ic, input bit acc,
                       input bit fl);
    push_valid_i = v;
    push_instr_i = {i1, i0};
    push_pc_i    = {p1, p0};
    issue_cnt_i  = ic;
    flush_i      = fl;
    if (acc && v[0]) exp_q.push_back('{pc: p0, instr: i0, dec: d0});
    if (acc && v[1]) exp_q.push_back('{pc: p1, instr: i1, dec: d1});
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    push_valid_i = '0;
    issue_cnt_i  = '0;
    flush_i      = 1'b0;
  endtask

  task automatic push_ori_pair(input logic [1:0] v, input logic [1:0] ic, input bit acc);
    drive(v, ori_n(n), pc_n(n), e_ori(), ori_n(n+1), pc_n(n+1), e_ori(), ic, acc, 1'b0);
    if (acc) n = n + (v[1] ? 2 : 1);
  endtask

  // Monitor: every slot consumed this cycle must match the oldest expected entry
  always @(negedge clk) begin
    if (resetn && !flush_i) begin
      for (int k = 0; k < int'(issue_cnt_i); k++) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL sb_underflow slot=%0d actual=issued expected=empty", k);
        end else begin
          mon_e = exp_q.pop_front();
          chk("slot_valid", 64'(slot_valid_o[k]), 64'd1);
          chk("slot_pc", 64'(slot_pc_o[32*k +: 32]), 64'(mon_e.pc));
          chk("slot_instr", 64'(slot_instr_o[32*k +: 32]), 64'(mon_e.instr));
          chk("slot_dec", 64'(slot_dec_o[k]), 64'(mon_e.dec));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn       = 1'b0;
    flush_i      = 1'b0;
    push_valid_i = '0;
    push_instr_i = '0;
    push_pc_i    = '0;
    issue_cnt_i  = '0;
    #3;
    chk("rst_valid", 64'(slot_valid_o), 64'd0);
    chk("rst_ready", 64'(push_ready_o), 64'd1);
    chk("rst_count", 64'(count_o), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;

    // ADDU + ORI pair, both slots valid next cycle
    drive(2'b11, I_ADDU, 32'h100, e_addu(), I_ORI, 32'h104, e_ori(), 2'd0, 1'b1, 1'b0);
    cyc();
    chk("pair_count", 64'(count_o), 64'd2);
    chk("pair_valid", 64'(slot_valid_o), 64'd3);
    chk("s0_alu", 64'(slot_dec_o[0].alucontrol), 64'(ALU_ADDU));
    chk("s0_imm", 64'(slot_dec_o[0].use_imm), 64'd0);
    chk("s1_alu", 64'(slot_dec_o[1].alucontrol), 64'(ALU_OR));
    chk("s1_imm", 64'(slot_dec_o[1].use_imm), 64'd1);
    drive(2'b00, 0, 0, '0, 0, 0, '0, 2'd2, 1'b0, 1'b0);
    cyc();
    chk("pair_drain", 64'(count_o), 64'd0);

    // Branch blocks its delay slot until the next cycle
    drive(2'b11, I_BEQ, 32'h200, e_beq(), I_ADDIU, 32'h204, e_addiu(), 2'd0, 1'b1, 1'b0);
    cyc();
    chk("br_valid", 64'(slot_valid_o), 64'd1);
    chk("br_flag", 64'(slot_dec_o[0].branch), 64'd1);
    chk("br_s1_instr", 64'(slot_instr_o[63:32]), 64'd0);
    chk("br_s1_dec", 64'(slot_dec_o[1]), 64'd0);
    drive(2'b00, 0, 0, '0, 0, 0, '0, 2'd1, 1'b0, 1'b0);
    cyc();
    chk("ds_valid", 64'(slot_valid_o), 64'd1);
    chk("ds_instr", 64'(slot_instr_o[31:0]), 64'(I_ADDIU));
    chk("ds_count", 64'(count_o), 64'd1);
    drive(2'b00, 0, 0, '0, 0, 0, '0, 2'd1, 1'b0, 1'b0);
    cyc();

    // COP0 CO with bad funct vs ERET
    drive(2'b11, I_CO19, 32'h300, e_invalid(), I_ERET, 32'h304, e_eret(), 2'd0, 1'b1, 1'b0);
    cyc();
    chk("co_valid", 64'(slot_valid_o), 64'd3);
    chk("co19_inv", 64'(slot_dec_o[0].invalid), 64'd1);
    chk("eret_inv", 64'(slot_dec_o[1].invalid), 64'd0);
    drive(2'b00, 0, 0, '0, 0, 0, '0, 2'd2, 1'b0, 1'b0);
    cyc();
    chk("co_count", 64'(count_o), 64'd0);

    // Fill to 7, ready drops, rejected push, then wrap over several laps
    for (int i = 0; i < 3; i++) begin
      push_ori_pair(2'b11, 2'd0, 1'b1);
      cyc();
    end
    chk("fill6_ready", 64'(push_ready_o), 64'd1);
    push_ori_pair(2'b01, 2'd0, 1'b1);
    cyc();
    chk("fill7_count", 64'(count_o), 64'd7);
    chk("fill7_ready", 64'(push_ready_o), 64'd0);
    push_ori_pair(2'b11, 2'd0, 1'b0);
    cyc();
    chk("reject_count", 64'(count_o), 64'd7);
    drive(2'b00, 0, 0, '0, 0, 0, '0, 2'd1, 1'b0, 1'b0);
    cyc();
    chk("iss1_ready", 64'(push_ready_o), 64'd1);
    chk("iss1_count", 64'(count_o), 64'd6);
    for (int i = 0; i < 12; i++) begin
      push_ori_pair(2'b11, 2'd2, 1'b1);
      cyc();
      chk("lap_count", 64'(count_o), 64'd6);
    end
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, 0, 0, '0, 0, 0, '0, 2'd2, 1'b0, 1'b0);
      cyc();
    end
    chk("lap_drain", 64'(count_o), 64'd0);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    // Flush with 5 entries while pushing and issuing
    push_ori_pair(2'b11, 2'd0, 1'b1); cyc();
    push_ori_pair(2'b11, 2'd0, 1'b1); cyc();
    push_ori_pair(2'b01, 2'd0, 1'b1); cyc();
    chk("pre_flush", 64'(count_o), 64'd5);
    drive(2'b11, I_ADDU, 32'h400, e_addu(), I_ORI, 32'h404, e_ori(), 2'd2, 1'b0, 1'b1);
    cyc();
    exp_q.delete();
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(slot_valid_o), 64'd0);
    drive(2'b11, I_ADDU, 32'h500, e_addu(), I_ORI, 32'h504, e_ori(), 2'd0, 1'b1, 1'b0);
    cyc();
    chk("post_flush", 64'(count_o), 64'd2);
    drive(2'b00, 0, 0, '0, 0, 0, '0, 2'd2, 1'b0, 1'b0);
    cyc();

    // Asynchronous reset mid-cycle with 4 entries
    push_ori_pair(2'b11, 2'd0, 1'b1); cyc();
    push_ori_pair(2'b11, 2'd0, 1'b1); cyc();
    chk("pre_rst", 64'(count_o), 64'd4);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_valid", 64'(slot_valid_o), 64'd0);
    chk("arst_count", 64'(count_o), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    chk("arst_ready", 64'(push_ready_o), 64'd1);
    push_ori_pair(2'b11, 2'd0, 1'b1);
    cyc();
    drive(2'b00, 0, 0, '0, 0, 0, '0, 2'd2, 1'b0, 1'b0);
    cyc();
    chk("end_count", 64'(count_o), 64'd0);
    chk("end_sb", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
